// File: rtl/spi_slave_driver.sv
// rtl/spi_slave_driver.sv - SPI mode-0 slave: shifts words in on mosi and out on miso, MSB first.
// sclk/cs/mosi are assumed already synchronous to clk; edges come from a one-cycle sclk history.
module spi_slave_driver #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  sclk,
  input  logic                  cs
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                  sclk_prev;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic                  sclk_rise;
  logic                  sclk_fall;

  assign sclk_rise = sclk & ~sclk_prev & ~cs;
  assign sclk_fall = ~sclk & sclk_prev & ~cs;

  // Between words the MSB comes straight from data_in so it is valid before the first rise.
  assign miso = cs ? 1'b0 : ((bit_cnt == '0) ? data_in[DATA_WIDTH-1] : tx_reg[DATA_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      rx_reg    <= '0;
      tx_reg    <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
    end else begin
      sclk_prev <= sclk;
      ready     <= 1'b0;
      if (cs) begin
        bit_cnt <= '0;
        rx_reg  <= '0;
        tx_reg  <= '0;
      end else if (sclk_rise) begin
        rx_reg  <= {rx_reg[DATA_WIDTH-2:0], mosi};
        bit_cnt <= bit_cnt + CNT_ONE;
        if (bit_cnt == '0) begin
          tx_reg <= data_in;
        end
      end else if (sclk_fall) begin
        // The fall after the last rise closes the word; earlier falls advance miso.
        if (bit_cnt == CNT_FULL) begin
          data_out <= rx_reg;
          ready    <= 1'b1;
          bit_cnt  <= '0;
        end else if (bit_cnt != '0) begin
          tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_driver.sv
// tb/tb_spi_slave_driver.sv - self-checking bench for spi_slave_driver with DATA_WIDTH=4.
// Directed vector table, abort/reset sequences, then randomized words against a word-level model.
module tb_spi_slave_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         ready;
  logic         mosi;
  logic         miso;
  logic         sclk;
  logic         cs;

  int passed = 0;
  int total  = 0;

  spi_slave_driver #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .ready(ready),
    .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] mosi_w;
    int           half;
    bit           b2b;
    bit           idle_before;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full word; miso is sampled just before each rise, ready is counted over the whole word.
  task automatic send_word(input logic [W-1:0] din, input logic [W-1:0] mw, input int half,
                           input bit b2b, output logic [W-1:0] miso_bits,
                           output int rdy_mid, output logic rdy_end);
    data_in = din;
    rdy_mid = 0;
    for (int i = W - 1; i >= 0; i--) begin
      mosi = mw[i];
      sclk = 1'b0;
      if (!(b2b && i == W - 1)) begin
        repeat (half) begin @(negedge clk); rdy_mid += int'(ready); end
      end
      #1;
      miso_bits[i] = miso;
      sclk = 1'b1;
      repeat (half) begin @(negedge clk); rdy_mid += int'(ready); end
    end
    sclk = 1'b0;
    @(negedge clk);
    rdy_end = ready;
  endtask

  task automatic partial_word(input logic [W-1:0] mw, input int nbits, input int half,
                              input bit raise_cs, output int rdy);
    rdy = 0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      mosi = mw[i];
      sclk = 1'b0;
      repeat (half) begin @(negedge clk); rdy += int'(ready); end
      sclk = 1'b1;
      repeat (half) begin @(negedge clk); rdy += int'(ready); end
    end
    if (raise_cs) begin
      cs   = 1'b1;
      sclk = 1'b0;
      repeat (3) begin @(negedge clk); rdy += int'(ready); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] mb;
    logic [W-1:0] model_out;
    logic [W-1:0] din_r;
    logic [W-1:0] mw_r;
    int           rm;
    int           rp;
    logic         re;
    bit           b2b_r;

    vecs[0] = '{din: 4'b1010, mosi_w: 4'hA, half: 1, b2b: 1'b0, idle_before: 1'b1, exp_out: 4'hA, exp_miso: 4'b1010};
    vecs[1] = '{din: 4'b0110, mosi_w: 4'hB, half: 1, b2b: 1'b1, idle_before: 1'b0, exp_out: 4'hB, exp_miso: 4'b0110};
    vecs[2] = '{din: 4'b1010, mosi_w: 4'hA, half: 2, b2b: 1'b0, idle_before: 1'b1, exp_out: 4'hA, exp_miso: 4'b1010};
    vecs[3] = '{din: 4'b0110, mosi_w: 4'hB, half: 2, b2b: 1'b1, idle_before: 1'b0, exp_out: 4'hB, exp_miso: 4'b0110};

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_miso_cs_high", 32'(miso), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].idle_before) begin
        data_in = vecs[v].din;
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_miso_idle", v), 32'(miso), 32'h0);
        cs = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_miso_first", v), 32'(miso), 32'(vecs[v].din[W-1]));
      end
      send_word(vecs[v].din, vecs[v].mosi_w, vecs[v].half, vecs[v].b2b, mb, rm, re);
      check($sformatf("v%0d_miso_bits", v), 32'(mb), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_ready_mid", v), 32'(rm), 32'h0);
      check($sformatf("v%0d_ready_end", v), 32'(re), 32'h1);
      check($sformatf("v%0d_data_out", v), 32'(data_out), 32'(vecs[v].exp_out));
      if (v == 3 || !vecs[v + 1].b2b) begin
        @(negedge clk);
        check($sformatf("v%0d_ready_drop", v), 32'(ready), 32'h0);
        check($sformatf("v%0d_data_hold", v), 32'(data_out), 32'(vecs[v].exp_out));
      end
    end
    model_out = 4'hB;

    // Aborted word followed by a full word.
    partial_word(4'hC, 2, 1, 1'b1, rp);
    check("abort_no_ready", 32'(rp), 32'h0);
    check("abort_data_hold", 32'(data_out), 32'(model_out));
    cs = 1'b0;
    @(negedge clk);
    send_word(4'h3, 4'h5, 1, 1'b0, mb, rm, re);
    check("after_abort_ready", 32'(re), 32'h1);
    check("after_abort_data", 32'(data_out), 32'h5);
    check("after_abort_miso", 32'(mb), 32'h3);

    // Reset in the middle of a word.
    partial_word(4'hE, 2, 1, 1'b0, rp);
    sclk = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("rst_mid_data_out", 32'(data_out), 32'h0);
    check("rst_mid_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    send_word(4'h9, 4'h6, 1, 1'b0, mb, rm, re);
    check("after_rst_ready", 32'(re), 32'h1);
    check("after_rst_data", 32'(data_out), 32'h6);
    check("after_rst_miso", 32'(mb), 32'h9);
    model_out = 4'h6;

    // Randomized words and aborts against the word-level model.
    b2b_r = 1'b0;
    for (int n = 0; n < 40; n++) begin
      din_r = W'($urandom);
      mw_r  = W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        partial_word(mw_r, $urandom_range(1, W - 1), $urandom_range(1, 3), 1'b1, rp);
        check($sformatf("rnd%0d_abort_ready", n), 32'(rp), 32'h0);
        check($sformatf("rnd%0d_abort_data", n), 32'(data_out), 32'(model_out));
        cs = 1'b0;
        @(negedge clk);
        b2b_r = 1'b0;
      end else begin
        send_word(din_r, mw_r, $urandom_range(1, 3), b2b_r, mb, rm, re);
        model_out = mw_r;
        check($sformatf("rnd%0d_miso", n), 32'(mb), 32'(din_r));
        check($sformatf("rnd%0d_ready", n), 32'({rm[7:0], 7'b0, re}), 32'h1);
        check($sformatf("rnd%0d_data", n), 32'(data_out), 32'(model_out));
        b2b_r = ($urandom_range(0, 1) == 1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
